// File: rtl/divider_pipeline_pkg.sv
// Shared definitions for the iterative radix-2 divider: op encodings,
// FSM states and the default datapath width.
package divider_pipeline_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [2:0] OP_DIV  = 3'b100;
    localparam logic [2:0] OP_DIVU = 3'b101;
    localparam logic [2:0] OP_REM  = 3'b110;
    localparam logic [2:0] OP_REMU = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/divider_pipeline_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and keep the trial difference when it does not borrow.
module divider_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic            dvd_bit,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_nxt,
    output logic            q_bit
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // rem < divisor on entry, so a wrap into bit XLEN is exactly a borrow
    assign shifted = {rem, dvd_bit};
    assign diff    = shifted - {1'b0, divisor};
    assign q_bit   = ~diff[XLEN];
    assign rem_nxt = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];

endmodule

// File: rtl/divider_pipeline.sv
// RV32M DIV/DIVU/REM/REMU unit: one quotient bit per cycle on magnitudes,
// special cases resolved at accept, result held until the pipeline moves on.
module divider_pipeline
    import divider_pipeline_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            flush,
    input  logic            valid_in,
    input  logic [XLEN-1:0] rs1_value,
    input  logic [XLEN-1:0] rs2_value,
    input  logic [2:0]      ctrl,
    output logic            busy,
    output logic            valid_out,
    output logic [XLEN-1:0] ans
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] rem, dvd, dsr;
    logic            q_neg, r_neg, is_rem;

    logic            signed_op, rs1_neg, rs2_neg;
    logic            div_zero, ovf, special, accept;
    logic [XLEN-1:0] rem_nxt, dvd_nxt, q_fix, r_fix;
    logic            q_bit;
    logic            unused_ctrl;

    assign unused_ctrl = ctrl[2];

    assign signed_op = ~ctrl[0];
    assign rs1_neg   = signed_op & rs1_value[XLEN-1];
    assign rs2_neg   = signed_op & rs2_value[XLEN-1];
    assign div_zero  = (rs2_value == '0);
    assign ovf       = signed_op && (rs1_value == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_value == '1);
    assign special   = div_zero | ovf;
    assign accept    = (state == IDLE) && valid_in && !stall && !flush;

    assign busy      = (state != IDLE);
    assign valid_out = (state == DONE);

    // dvd doubles as the quotient register: dividend bits leave the top as
    // quotient bits enter the bottom
    divider_step #(.XLEN(XLEN)) u_step (
        .rem     (rem),
        .dvd_bit (dvd[XLEN-1]),
        .divisor (dsr),
        .rem_nxt (rem_nxt),
        .q_bit   (q_bit)
    );

    assign dvd_nxt = {dvd[XLEN-2:0], q_bit};
    assign q_fix   = q_neg ? -dvd_nxt : dvd_nxt;
    assign r_fix   = r_neg ? -rem_nxt : rem_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else if (!stall)
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (valid_in) state_nxt = special ? DONE : CALC;
            CALC:    if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush)
            state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            rem    <= '0;
            dvd    <= '0;
            dsr    <= '0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            is_rem <= 1'b0;
            ans    <= '0;
        end else if (!stall && !flush) begin
            if (accept) begin
                if (div_zero)
                    ans <= ctrl[1] ? rs1_value : '1;
                else if (ovf)
                    ans <= ctrl[1] ? '0 : rs1_value;
                else begin
                    dvd    <= rs1_neg ? -rs1_value : rs1_value;
                    dsr    <= rs2_neg ? -rs2_value : rs2_value;
                    q_neg  <= rs1_neg ^ rs2_neg;
                    r_neg  <= rs1_neg;
                    is_rem <= ctrl[1];
                    rem    <= '0;
                    cnt    <= '0;
                end
            end else if (state == CALC) begin
                rem <= rem_nxt;
                dvd <= dvd_nxt;
                cnt <= cnt + 1'b1;
                if (cnt == LAST)
                    ans <= is_rem ? r_fix : q_fix;
            end
        end
    end

endmodule

// File: tb/tb_divider_pipeline.sv
// Scoreboard bench for divider_pipeline: a driver pushes reference results
// at each accept, a monitor pops and compares on every valid_out pulse.
module tb_divider_pipeline;
    import divider_pipeline_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        valid_in = 1'b0;
    logic [31:0] rs1_value = '0;
    logic [31:0] rs2_value = '0;
    logic [2:0]  ctrl = OP_DIVU;
    logic        busy, valid_out;
    logic [31:0] ans;

    divider_pipeline #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (stall),
        .flush     (flush),
        .valid_in  (valid_in),
        .rs1_value (rs1_value),
        .rs2_value (rs2_value),
        .ctrl      (ctrl),
        .busy      (busy),
        .valid_out (valid_out),
        .ans       (ans)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ans;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: RISC-V division semantics with plain integer arithmetic
    function automatic logic [31:0] ref_ans(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        logic [31:0] q, r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!op[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = a;
                r = 32'd0;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
        return op[1] ? r : q;
    endfunction

    function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        if (b == 32'd0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))
            return 1;
        return 33;
    endfunction

    initial begin
        logic vo_q;
        exp_t e;
        vo_q = 1'b0;
        forever begin
            @(negedge clk);
            if (valid_out && !vo_q) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid_out", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("ans", ans, e.ans);
                    chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
                end
            end
            vo_q = valid_out;
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("wait_idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                          input bit push, input int extra_lat);
        exp_t e;
        wait_idle();
        rs1_value = a;
        rs2_value = b;
        ctrl      = op;
        valid_in  = 1'b1;
        @(posedge clk);
        #1;
        if (push) begin
            e.ans = ref_ans(a, b, op);
            e.lat = ref_lat(a, b, op) + extra_lat;
            e.acc = cyc;
            sb.push_back(e);
        end
        valid_in = 1'b0;
    endtask

    initial begin
        logic [2:0]  ops [4];
        logic [31:0] a, b;
        int          n;
        ops[0] = OP_DIV; ops[1] = OP_DIVU; ops[2] = OP_REM; ops[3] = OP_REMU;

        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_valid_out", 32'(valid_out), 32'd0);
        chk("reset_ans", ans, 32'd0);
        #21 rst_n = 1'b1;

        run_op(32'd100, 32'd7, OP_DIVU, 1, 0);
        run_op(32'd100, 32'd7, OP_REMU, 1, 0);
        run_op(32'hFFFF_FFF9, 32'd2, OP_DIV, 1, 0);
        run_op(32'hFFFF_FFF9, 32'd2, OP_REM, 1, 0);
        run_op(32'h1234_5678, 32'd0, OP_DIV, 1, 0);
        run_op(32'h1234_5678, 32'd0, OP_REM, 1, 0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, OP_DIV, 1, 0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, OP_REM, 1, 0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, OP_DIVU, 1, 0);

        // mid-CALC stall of 5 cycles, with a request that must be ignored
        run_op(32'hFFFF_FFFF, 32'd3, OP_DIVU, 1, 5);
        repeat (10) @(posedge clk);
        @(negedge clk);
        stall = 1'b1;
        valid_in = 1'b1;
        rs1_value = 32'd5;
        rs2_value = 32'd1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        stall = 1'b0;
        valid_in = 1'b0;
        n = 0;
        while (!valid_out && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("stall_op_done", 32'(valid_out), 32'd1);
        // hold DONE under stall while a request is presented
        stall = 1'b1;
        valid_in = 1'b1;
        rs1_value = 32'd9;
        rs2_value = 32'd3;
        repeat (3) begin
            @(negedge clk);
            chk("done_stall_valid", 32'(valid_out), 32'd1);
            chk("done_stall_ans", ans, 32'h5555_5555);
        end
        stall = 1'b0;
        @(negedge clk);
        valid_in = 1'b0;
        chk("done_no_accept_busy", 32'(busy), 32'd0);
        chk("done_pulse_end", 32'(valid_out), 32'd0);

        // flush in IDLE blocks acceptance
        wait_idle();
        valid_in = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        flush = 1'b0;
        chk("idle_flush_busy", 32'(busy), 32'd0);

        // flush at edge 10 of an op kills it
        run_op(32'd1000, 32'd10, OP_DIVU, 0, 0);
        repeat (8) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_valid_out", 32'(valid_out), 32'd0);
        run_op(32'd9, 32'd3, OP_DIVU, 1, 0);

        // asynchronous reset mid-CALC
        run_op(32'd1000, 32'd10, OP_DIVU, 0, 0);
        repeat (6) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_valid", 32'(valid_out), 32'd0);
        chk("async_rst_ans", ans, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(32'd9, 32'd3, OP_DIVU, 1, 0);

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 5))
                0: begin a = $urandom; b = 32'd0; end
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = $urandom_range(0, 500); b = $urandom_range(1, 20); end
                3: begin a = -32'($urandom_range(0, 500)); b = -32'($urandom_range(1, 20)); end
                default: begin a = $urandom; b = $urandom >> $urandom_range(0, 31); end
            endcase
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_op(a, b, ops[$urandom_range(0, 3)], 1, 0);
        end

        n = 0;
        while ((busy || sb.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
